// File: rtl/mem_stage_if.sv
// Data-bus handshake between the memory-access stage (master) and the memory
// system (slave): one outstanding req/ack access at a time.
interface mem_stage_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic [31:0] busRdata;
  logic        busAck;

  modport master (
    output busReq, busWe, busAddr, busBe, busWdata,
    input  busRdata, busAck
  );

  modport slave (
    input  busReq, busWe, busAddr, busBe, busWdata,
    output busRdata, busAck
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack bus, stalls the
// pipeline while an access is outstanding, and hands the write-back triple to MEM/WB.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  memALUop,
  input  logic [31:0] memAddr,
  input  logic [31:0] memReg,
  input  logic [4:0]  memWriteNum,
  input  logic        memWriteReg,
  input  logic [31:0] memWriteData,
  mem_stage_if.master bus,
  output logic [4:0]  wbWriteNum,
  output logic        wbWriteReg,
  output logic [31:0] wbWriteData,
  output logic        stallReq,
  output logic        misaligned,
  output logic        busErr
);

  localparam logic [4:0] OP_LB  = 5'h10;
  localparam logic [4:0] OP_LBU = 5'h11;
  localparam logic [4:0] OP_LH  = 5'h12;
  localparam logic [4:0] OP_LHU = 5'h13;
  localparam logic [4:0] OP_LW  = 5'h14;
  localparam logic [4:0] OP_SB  = 5'h15;
  localparam logic [4:0] OP_SH  = 5'h16;
  localparam logic [4:0] OP_SW  = 5'h17;

  // Counter only has to reach TIMEOUT-1 (see the REQ branch below).
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [1:0]  lane;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [4:0]  num;
    logic        wreg;
    logic [31:0] alu;
  } acc_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] rdata_q;
  acc_t        acc, acc_n;
  logic        req_q, err_pulse, err_q;

  logic is_mem, is_store, is_half, is_word, mis, issue;

  function automatic logic [31:0] fmt_load(input logic [4:0] op, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   fmt_load = {{24{b[7]}}, b};
      OP_LBU:  fmt_load = {24'h0, b};
      OP_LH:   fmt_load = {{16{h[15]}}, h};
      OP_LHU:  fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Memory ops occupy the contiguous 0x10..0x17 block.
  assign is_mem   = (memALUop[4:3] == 2'b10);
  assign is_store = memALUop inside {OP_SB, OP_SH, OP_SW};
  assign is_half  = memALUop inside {OP_LH, OP_LHU, OP_SH};
  assign is_word  = memALUop inside {OP_LW, OP_SW};
  assign mis      = is_mem && ((is_half && memAddr[0]) || (is_word && (memAddr[1:0] != 2'b00)));
  assign issue    = is_mem && !mis;

  always_comb begin
    acc_n       = '0;
    acc_n.op    = memALUop;
    acc_n.lane  = memAddr[1:0];
    acc_n.we    = is_store;
    acc_n.addr  = {memAddr[31:2], 2'b00};
    acc_n.num   = memWriteNum;
    acc_n.wreg  = memWriteReg;
    acc_n.alu   = memWriteData;
    case (memALUop)
      OP_SB: begin
        acc_n.be    = 4'b0001 << memAddr[1:0];
        acc_n.wdata = {4{memReg[7:0]}};
      end
      OP_SH: begin
        acc_n.be    = memAddr[1] ? 4'b1100 : 4'b0011;
        acc_n.wdata = {2{memReg[15:0]}};
      end
      OP_SW: begin
        acc_n.be    = 4'b1111;
        acc_n.wdata = memReg;
      end
      default: begin
        acc_n.be    = 4'b1111;
        acc_n.wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      acc       <= '0;
      req_q     <= 1'b0;
      err_pulse <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state <= REQ;
            req_q <= 1'b1;
            cnt   <= '0;
            err_q <= 1'b0;
            acc   <= acc_n;
          end
        end
        REQ: begin
          if (bus.busAck) begin
            rdata_q <= fmt_load(acc.op, acc.lane, bus.busRdata);
            req_q   <= 1'b0;
            cnt     <= '0;
            state   <= DONE;
          // cnt holds the number of completed REQ cycles minus one, so this is
          // the edge that ends the TIMEOUT-th ack-less cycle.
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_pulse <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= '0;
            req_q     <= 1'b0;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busReq   = req_q;
  assign bus.busWe    = acc.we;
  assign bus.busAddr  = acc.addr;
  assign bus.busBe    = acc.be;
  assign bus.busWdata = acc.wdata;
  assign busErr       = err_pulse;

  // Combinational outputs are forced low while reset is held so that nothing
  // leaks to MEM/WB or the stall controller during reset.
  always_comb begin
    stallReq    = 1'b0;
    misaligned  = 1'b0;
    wbWriteNum  = '0;
    wbWriteReg  = 1'b0;
    wbWriteData = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          wbWriteNum  = memWriteNum;
          wbWriteData = memWriteData;
          if (!is_mem)  wbWriteReg = memWriteReg;
          else if (mis) misaligned = 1'b1;
          else          stallReq   = 1'b1;
        end
        REQ: begin
          stallReq    = 1'b1;
          wbWriteNum  = acc.num;
          wbWriteData = acc.alu;
        end
        DONE: begin
          wbWriteNum  = acc.num;
          wbWriteReg  = acc.wreg && !acc.we && !err_q;
          wbWriteData = acc.we ? acc.alu : rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-back and bus
// transactions; monitor and bus responder pop and compare as the DUT presents them.
module tb_mem_stage;

  localparam logic [4:0] ADD = 5'h01;
  localparam logic [4:0] LB  = 5'h10;
  localparam logic [4:0] LBU = 5'h11;
  localparam logic [4:0] LH  = 5'h12;
  localparam logic [4:0] LHU = 5'h13;
  localparam logic [4:0] LW  = 5'h14;
  localparam logic [4:0] SB  = 5'h15;
  localparam logic [4:0] SH  = 5'h16;
  localparam logic [4:0] SW  = 5'h17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  memALUop;
  logic [31:0] memAddr, memReg, memWriteData;
  logic [4:0]  memWriteNum;
  logic        memWriteReg;
  logic [4:0]  wbWriteNum;
  logic        wbWriteReg;
  logic [31:0] wbWriteData;
  logic        stallReq, misaligned, busErr;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .memALUop     (memALUop),
    .memAddr      (memAddr),
    .memReg       (memReg),
    .memWriteNum  (memWriteNum),
    .memWriteReg  (memWriteReg),
    .memWriteData (memWriteData),
    .bus          (bus),
    .wbWriteNum   (wbWriteNum),
    .wbWriteReg   (wbWriteReg),
    .wbWriteData  (wbWriteData),
    .stallReq     (stallReq),
    .misaligned   (misaligned),
    .busErr       (busErr)
  );

  typedef struct {
    logic [4:0]  num;
    logic        wreg;
    logic [31:0] data;
    int          stall;
    logic        mis;
    logic        err;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
    int          len;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  int          tests = 0, fails = 0;
  int          rises = 0, err_cycles = 0;
  int          ack_wait = 1000;
  logic [31:0] rd_val = '0;
  logic        ex_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_wb(input logic [4:0] num, input logic wreg, input logic [31:0] data,
                        input int stall, input logic mis, input logic err);
    wb_exp_t e;
    e.num = num; e.wreg = wreg; e.data = data; e.stall = stall; e.mis = mis; e.err = err;
    wb_q.push_back(e);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic chk_wd, input int len);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.chk_wd = chk_wd; e.len = len;
    bus_q.push_back(e);
  endtask

  // Present one instruction and hold it until the stage stops stalling.
  task automatic op_run(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] regv,
                        input logic [4:0] num, input logic wreg, input logic [31:0] alu,
                        input logic [31:0] rdata, input int waitc);
    bit done;
    memALUop = op; memAddr = addr; memReg = regv;
    memWriteNum = num; memWriteReg = wreg; memWriteData = alu;
    rd_val = rdata; ack_wait = waitc; ex_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stallReq) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL retire_timeout: op %0h still stalling after 40 cycles", op);
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    int      stall_cnt;
    wb_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) stall_cnt = 0;
      else if (ex_valid) begin
        if (stallReq) stall_cnt++;
        else begin
          chk("wb_queue_nonempty", 64'(wb_q.size() != 0), 64'(1));
          if (wb_q.size() != 0) begin
            e = wb_q.pop_front();
            chk("wbWriteNum", 64'(wbWriteNum), 64'(e.num));
            chk("wbWriteReg", 64'(wbWriteReg), 64'(e.wreg));
            if (e.wreg) chk("wbWriteData", 64'(wbWriteData), 64'(e.data));
            chk("misaligned", 64'(misaligned), 64'(e.mis));
            chk("stall_cycles", 64'(stall_cnt), 64'(e.stall));
            chk("busErr_at_retire", 64'(busErr), 64'(e.err));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin : responder
    logic     prev;
    int       len;
    bus_exp_t cur;
    prev = 1'b0; len = 0;
    cur = '{we: 1'b0, addr: '0, be: '0, wdata: '0, chk_wd: 1'b0, len: 0};
    bus.busAck = 1'b0; bus.busRdata = 32'h0BAD_0BAD;
    forever begin
      @(negedge clk);
      if (busErr) err_cycles++;
      if (bus.busReq) begin
        if (!prev) begin
          rises++;
          len = 0;
          chk("bus_queue_nonempty", 64'(bus_q.size() != 0), 64'(1));
          if (bus_q.size() != 0) cur = bus_q.pop_front();
        end
        chk("busWe", 64'(bus.busWe), 64'(cur.we));
        chk("busAddr", 64'(bus.busAddr), 64'(cur.addr));
        chk("busBe", 64'(bus.busBe), 64'(cur.be));
        if (cur.chk_wd) chk("busWdata", 64'(bus.busWdata), 64'(cur.wdata));
        bus.busAck   = (len == ack_wait);
        bus.busRdata = bus.busAck ? rd_val : 32'h0BAD_0BAD;
        len++;
      end else begin
        if (prev) chk("req_cycles", 64'(len), 64'(cur.len));
        bus.busAck   = 1'b0;
        bus.busRdata = 32'h0BAD_0BAD;
      end
      prev = bus.busReq;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b0;
    memALUop = LW; memAddr = '0; memReg = '1;
    memWriteNum = 5'h1F; memWriteReg = 1'b1; memWriteData = '1;
    repeat (2) @(negedge clk);
    chk("rst_stallReq", 64'(stallReq), 64'(0));
    chk("rst_busReq", 64'(bus.busReq), 64'(0));
    chk("rst_wbWriteReg", 64'(wbWriteReg), 64'(0));
    chk("rst_wbWriteData", 64'(wbWriteData), 64'(0));
    chk("rst_wbWriteNum", 64'(wbWriteNum), 64'(0));
    chk("rst_busAddr", 64'(bus.busAddr), 64'(0));
    chk("rst_busErr", 64'(busErr), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1; memALUop = ADD;
    @(posedge clk); #1;

    exp_wb(5'd5, 1'b1, 32'h1234, 0, 1'b0, 1'b0);
    op_run(ADD, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 1000);

    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 4);
    exp_wb(5'd7, 1'b1, 32'hFFFF_FF80, 5, 1'b0, 1'b0);
    op_run(LB, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 32'h80FF_FFFF, 3);

    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 2);
    exp_wb(5'd8, 1'b1, 32'h0000_0080, 3, 1'b0, 1'b0);
    op_run(LBU, 32'h103, 32'h0, 5'd8, 1'b1, 32'h0, 32'h80FF_FFFF, 1);

    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 1);
    exp_wb(5'd9, 1'b1, 32'hFFFF_8001, 2, 1'b0, 1'b0);
    op_run(LH, 32'h102, 32'h0, 5'd9, 1'b1, 32'h0, 32'h8001_7FFF, 0);

    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b0, 3);
    exp_wb(5'd10, 1'b1, 32'h0000_F234, 4, 1'b0, 1'b0);
    op_run(LHU, 32'h100, 32'h0, 5'd10, 1'b1, 32'h0, 32'h8001_F234, 2);

    exp_bus(1'b1, 32'h40, 4'b0010, 32'hA5A5_A5A5, 1'b1, 1);
    exp_wb(5'd11, 1'b0, 32'h0, 2, 1'b0, 1'b0);
    op_run(SB, 32'h41, 32'h1234_56A5, 5'd11, 1'b1, 32'h0, 32'h0, 0);

    // SH followed immediately by LW: each must produce exactly one request.
    exp_bus(1'b1, 32'h20, 4'b1100, 32'hBEEF_BEEF, 1'b1, 1);
    exp_wb(5'd12, 1'b0, 32'h0, 2, 1'b0, 1'b0);
    op_run(SH, 32'h22, 32'hDEAD_BEEF, 5'd12, 1'b1, 32'h0, 32'h0, 0);
    exp_bus(1'b0, 32'h24, 4'b1111, 32'h0, 1'b0, 1);
    exp_wb(5'd13, 1'b1, 32'hCAFE_F00D, 2, 1'b0, 1'b0);
    op_run(LW, 32'h24, 32'h0, 5'd13, 1'b1, 32'h0, 32'hCAFE_F00D, 0);

    exp_wb(5'd14, 1'b0, 32'h0, 0, 1'b1, 1'b0);
    op_run(LW, 32'h41, 32'h0, 5'd14, 1'b1, 32'h0, 32'h0, 0);
    exp_wb(5'd15, 1'b0, 32'h0, 0, 1'b1, 1'b0);
    op_run(SH, 32'h23, 32'h0, 5'd15, 1'b1, 32'h0, 32'h0, 0);

    exp_bus(1'b1, 32'h80, 4'b1111, 32'h1122_3344, 1'b1, 4);
    exp_wb(5'd16, 1'b0, 32'h0, 5, 1'b0, 1'b1);
    op_run(SW, 32'h80, 32'h1122_3344, 5'd16, 1'b1, 32'h0, 32'h0, 1000);

    exp_wb(5'd17, 1'b1, 32'hABCD, 0, 1'b0, 1'b0);
    op_run(ADD, 32'h0, 32'h0, 5'd17, 1'b1, 32'hABCD, 32'h0, 1000);

    // Reset asserted while a load is waiting for its ack.
    ex_valid = 1'b0;
    exp_bus(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 2);
    memALUop = LW; memAddr = 32'h200; memWriteNum = 5'd19; memWriteReg = 1'b1;
    memWriteData = 32'h7777; ack_wait = 1000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busReq", 64'(bus.busReq), 64'(0));
    chk("abort_stallReq", 64'(stallReq), 64'(0));
    chk("abort_busWe_Be", 64'({bus.busWe, bus.busBe}), 64'(0));
    chk("abort_busAddr", 64'(bus.busAddr), 64'(0));
    chk("abort_wb", 64'({wbWriteNum, wbWriteReg, wbWriteData}), 64'(0));
    chk("abort_misaligned_err", 64'({misaligned, busErr}), 64'(0));
    rst = 1'b1; memALUop = ADD;
    @(posedge clk); #1;

    exp_bus(1'b0, 32'h200, 4'b1111, 32'h0, 1'b0, 1);
    exp_wb(5'd18, 1'b1, 32'h5555_AAAA, 2, 1'b0, 1'b0);
    op_run(LW, 32'h200, 32'h0, 5'd18, 1'b1, 32'h0, 32'h5555_AAAA, 0);
    ex_valid = 1'b0;
    memALUop = ADD;

    repeat (3) @(negedge clk);
    chk("wb_queue_drained", 64'(wb_q.size()), 64'(0));
    chk("bus_queue_drained", 64'(bus_q.size()), 64'(0));
    chk("bus_request_count", 64'(rises), 64'(10));
    chk("busErr_cycles", 64'(err_cycles), 64'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
